// File: rtl/tournament_pkg.sv
// tournament_pkg
//   Shared definitions for the tournament branch predictor:
//   - sweep_state_e   : table-initialisation sweep states
//   - META_GHR_LSB    : bit offset of the history snapshot inside pred_meta/upd_meta
//   - meta_gsh_bit    : bit position of gsh_pred inside the meta word
//   - meta_bim_bit    : bit position of bim_pred inside the meta word
//   - weak_init       : power-up value of a counter ("weakly not taken")
//   - sat_update      : saturating increment/decrement of a counter
package tournament_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } sweep_state_e;

  // Meta word layout: {bim_pred, gsh_pred, ghr_snapshot[GHR_BITS-1:0]}
  localparam int META_GHR_LSB = 0;

  function automatic int meta_gsh_bit(input int ghr_bits);
    return ghr_bits;
  endfunction

  function automatic int meta_bim_bit(input int ghr_bits);
    return ghr_bits + 1;
  endfunction

  // 2^(width-1)-1: the largest value whose MSB is still 0
  function automatic logic [31:0] weak_init(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  // Counters stick at 0 and at 2^width-1 instead of wrapping
  function automatic logic [31:0] sat_update(input logic [31:0] value,
                                             input int unsigned width,
                                             input logic inc);
    logic [31:0] max_val;
    max_val = (32'd1 << width) - 32'd1;
    if (inc) begin
      return (value >= max_val) ? max_val : value + 32'd1;
    end
    return (value == 32'd0) ? 32'd0 : value - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter_table.sv
// sat_counter_table
//   Table of 2^IDX_BITS saturating counters, each WIDTH bits wide.
//   Ports:
//     clk      in   clock
//     rd_idx   in   read index (combinational read port)
//     rd_data  out  counter value at rd_idx, before any same-cycle write
//     wr_en    in   write strobe
//     wr_idx   in   write index
//     wr_init  in   1: load the weak init value, 0: saturating update
//     wr_inc   in   update direction (1 = increment, 0 = decrement)
module sat_counter_table
  import tournament_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int IDX_BITS = 10
) (
  input  logic                clk,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [WIDTH-1:0]    rd_data,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_init,
  input  logic                wr_inc
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(weak_init(WIDTH));

  logic [WIDTH-1:0] mem [ENTRIES];

  // The read is asynchronous, so a write to the same entry only becomes
  // visible after the clock edge (read-before-write).
  assign rd_data = mem[rd_idx];

  // The write port does its own read-modify-write on wr_idx so the caller
  // never needs a second read port for training.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_init ? INIT_VAL
                             : WIDTH'(sat_update(32'(mem[wr_idx]), WIDTH, wr_inc));
    end
  end

endmodule

// File: rtl/tournament_predictor.sv
// tournament_predictor
//   Bimodal + gshare tournament branch predictor with a per-PC selector.
//   Ports:
//     clk, reset      clock, synchronous active-high reset
//     pred_req/pc     prediction request and branch PC
//     pred_valid      result valid (one cycle after an accepted request)
//     pred_taken      final prediction
//     pred_meta       {bim_pred, gsh_pred, ghr_snapshot} to carry with the branch
//     upd_valid/pc    resolve event and resolved PC
//     upd_taken       actual outcome
//     upd_meta        meta word that was returned with the prediction
//     upd_mispredict  final prediction was wrong (triggers history recovery)
//     init_done       all tables swept to their init values
module tournament_predictor
  import tournament_pkg::*;
#(
  parameter int IDX_BITS = 10,
  parameter int GHR_BITS = 10,
  parameter int CTR_BITS = 2,
  parameter int SEL_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pred_req,
  input  logic [31:0]         pred_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [GHR_BITS+1:0] pred_meta,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic [GHR_BITS+1:0] upd_meta,
  input  logic                upd_mispredict,
  output logic                init_done
);

  localparam int GSH_BIT = meta_gsh_bit(GHR_BITS);
  localparam int BIM_BIT = meta_bim_bit(GHR_BITS);

  sweep_state_e        state;
  logic [IDX_BITS-1:0] init_cnt;
  logic [GHR_BITS-1:0] ghr;

  logic [IDX_BITS-1:0] pred_idx, pred_gidx;
  logic [IDX_BITS-1:0] upd_idx, upd_gidx;
  logic [GHR_BITS-1:0] upd_ghr;
  logic                upd_bim, upd_gsh;
  logic [CTR_BITS-1:0] bim_rd, gsh_rd;
  logic [SEL_BITS-1:0] sel_rd;
  logic                bim_pred, gsh_pred, final_pred;
  logic                pred_fire, upd_fire;
  logic                wr_init, ctr_wr_en, sel_wr_en, sel_inc;
  logic [IDX_BITS-1:0] bim_wr_idx, gsh_wr_idx;
  logic                unused_pc_bits;

  // Only PC bits [IDX_BITS+1:2] index the tables
  assign unused_pc_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                            upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

  // Prediction-side indices use the live (speculative) history
  assign pred_idx  = pred_pc[IDX_BITS+1:2];
  assign pred_gidx = pred_idx ^ IDX_BITS'(ghr);

  // Update-side indices use the snapshot taken at prediction time, so the
  // trained gshare entry is the one that actually produced the prediction.
  assign upd_ghr  = upd_meta[META_GHR_LSB +: GHR_BITS];
  assign upd_gsh  = upd_meta[GSH_BIT];
  assign upd_bim  = upd_meta[BIM_BIT];
  assign upd_idx  = upd_pc[IDX_BITS+1:2];
  assign upd_gidx = upd_idx ^ IDX_BITS'(upd_ghr);

  assign bim_pred   = bim_rd[CTR_BITS-1];
  assign gsh_pred   = gsh_rd[CTR_BITS-1];
  assign final_pred = sel_rd[SEL_BITS-1] ? gsh_pred : bim_pred;

  assign pred_fire = pred_req && init_done;
  assign upd_fire  = upd_valid && init_done;

  // During the sweep the write ports belong to the init counter; afterwards
  // they carry resolve-time training. The selector only learns when the two
  // component predictors disagreed.
  assign wr_init    = (state == ST_INIT);
  assign bim_wr_idx = wr_init ? init_cnt : upd_idx;
  assign gsh_wr_idx = wr_init ? init_cnt : upd_gidx;
  assign ctr_wr_en  = wr_init || upd_fire;
  assign sel_wr_en  = wr_init || (upd_fire && (upd_bim != upd_gsh));
  assign sel_inc    = (upd_gsh == upd_taken);

  sat_counter_table #(.WIDTH(CTR_BITS), .IDX_BITS(IDX_BITS)) u_bim (
    .clk    (clk),
    .rd_idx (pred_idx),
    .rd_data(bim_rd),
    .wr_en  (ctr_wr_en),
    .wr_idx (bim_wr_idx),
    .wr_init(wr_init),
    .wr_inc (upd_taken)
  );

  sat_counter_table #(.WIDTH(CTR_BITS), .IDX_BITS(IDX_BITS)) u_gsh (
    .clk    (clk),
    .rd_idx (pred_gidx),
    .rd_data(gsh_rd),
    .wr_en  (ctr_wr_en),
    .wr_idx (gsh_wr_idx),
    .wr_init(wr_init),
    .wr_inc (upd_taken)
  );

  sat_counter_table #(.WIDTH(SEL_BITS), .IDX_BITS(IDX_BITS)) u_sel (
    .clk    (clk),
    .rd_idx (pred_idx),
    .rd_data(sel_rd),
    .wr_en  (sel_wr_en),
    .wr_idx (bim_wr_idx),
    .wr_init(wr_init),
    .wr_inc (sel_inc)
  );

  // Init sweep: one entry per cycle, READY after the last entry is written
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + IDX_BITS'(1);
          if (&init_cnt) begin
            state     <= ST_READY;
            init_done <= 1'b1;
          end
        end
        ST_READY: begin
          init_done <= 1'b1;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

  // Global history: mispredict recovery wins over a same-cycle speculative
  // shift. The sized casts drop the MSB, which also covers GHR_BITS=1.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (upd_fire && upd_mispredict) begin
      ghr <= GHR_BITS'({upd_ghr, upd_taken});
    end else if (pred_fire) begin
      ghr <= GHR_BITS'({ghr, final_pred});
    end
  end

  // Registered prediction results; taken/meta hold between requests
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_meta  <= '0;
    end else begin
      pred_valid <= pred_fire;
      if (pred_fire) begin
        pred_taken <= final_pred;
        pred_meta  <= {bim_pred, gsh_pred, ghr};
      end
    end
  end

endmodule
